// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline definitions: default raster geometry, coordinate
// and address types, and the line-generator state encoding.
package gfx_pkg;

    localparam int XW_DEF    = 10;
    localparam int YW_DEF    = 9;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int AW_DEF    = 19;

    typedef logic [XW_DEF-1:0] coord_x_t;
    typedef logic [YW_DEF-1:0] coord_y_t;
    typedef logic [AW_DEF-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } line_state_t;

endpackage

// File: rtl/bresen_line_gen_if.sv
// Command and pixel-stream bundle of the line generator.
// master: primitive decoder / frame-buffer writer side.
// slave : the line generator itself.
interface bresen_line_gen_if
    import gfx_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF,
    parameter int AW = AW_DEF
) ();

    logic          start;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic          abort;
    logic          busy;
    logic          pix_valid;
    logic          pix_ready;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [AW-1:0] pix_addr;
    logic          pix_last;
    logic          line_done;

    modport master (
        output start, x0, y0, x1, y1, abort, pix_ready,
        input  busy, pix_valid, pix_x, pix_y, pix_addr, pix_last, line_done
    );

    modport slave (
        input  start, x0, y0, x1, y1, abort, pix_ready,
        output busy, pix_valid, pix_x, pix_y, pix_addr, pix_last, line_done
    );

endinterface

// File: rtl/line_addr_map.sv
// Registered (x,y) -> y*H_RES + x linear frame-buffer address.
// Loaded with the coordinates that become current next cycle, so the
// address lines up with the registered pixel coordinates.
module line_addr_map #(
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int H_RES = 640,
    parameter int AW    = 19
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_en,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic [AW-1:0] o_addr
);

    localparam logic [AW-1:0] HRES_C = AW'(H_RES);

    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;

    assign w_addr = AW'(i_y) * HRES_C + AW'(i_x);

    // capture the address of the coordinates being loaded
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)    r_addr <= '0;
        else if (i_en) r_addr <= w_addr;
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/bresen_line_gen.sv
// Bresenham line rasteriser: one segment per start command, all octants,
// emitting on-screen pixels on a valid/ready stream and skipping clipped
// ones at one per cycle.
module bresen_line_gen
    import gfx_pkg::*;
#(
    parameter int XW    = XW_DEF,
    parameter int YW    = YW_DEF,
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF,
    parameter int AW    = AW_DEF
) (
    input logic              clk,
    input logic              n_rst,
    bresen_line_gen_if.slave bus
);

    // Two guard bits keep dx + dy and the accumulated error in range.
    localparam int EW = ((XW > YW) ? XW : YW) + 2;
    localparam logic [XW:0] HX = (XW+1)'(H_RES);
    localparam logic [YW:0] VY = (YW+1)'(V_RES);

    line_state_t r_state;
    logic [XW-1:0] r_x0, r_x1, r_cx;
    logic [YW-1:0] r_y0, r_y1, r_cy;
    logic signed [EW-1:0] r_dx, r_dy, r_err;
    logic r_sx_neg, r_sy_neg;
    logic r_busy, r_valid, r_last, r_done;

    logic [XW-1:0] w_dx_abs, w_x_step, w_nxt_x;
    logic [YW-1:0] w_dy_abs, w_y_step, w_nxt_y;
    logic signed [EW-1:0] w_dx_s, w_dy_s, w_err_nxt;
    logic signed [EW:0] w_e2, w_dx_e, w_dy_e;
    logic w_step_x, w_step_y, w_adv, w_at_end, w_ld, w_nxt_on, w_nxt_end;

    // setup magnitudes from the latched endpoints
    assign w_dx_abs = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    assign w_dy_abs = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
    assign w_dx_s   = {{(EW-XW){1'b0}}, w_dx_abs};
    assign w_dy_s   = {{(EW-YW){1'b0}}, w_dy_abs};

    // step decision on the doubled error
    assign w_e2     = {r_err, 1'b0};
    assign w_dx_e   = {r_dx[EW-1], r_dx};
    assign w_dy_e   = {r_dy[EW-1], r_dy};
    assign w_step_x = (w_e2 >= w_dy_e);
    assign w_step_y = (w_e2 <= w_dx_e);
    assign w_err_nxt = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);

    assign w_x_step = r_sx_neg ? (r_cx - 1'b1) : (r_cx + 1'b1);
    assign w_y_step = r_sy_neg ? (r_cy - 1'b1) : (r_cy + 1'b1);

    // A clipped pixel is never shown, so it retires without a handshake.
    assign w_at_end = (r_cx == r_x1) && (r_cy == r_y1);
    assign w_adv    = (r_state == DRAW) && !bus.abort && (!r_valid || bus.pix_ready);

    // Coordinates loaded next: the start point in SETUP, else the stepped point.
    assign w_nxt_x   = (r_state == SETUP) ? r_x0 : (w_step_x ? w_x_step : r_cx);
    assign w_nxt_y   = (r_state == SETUP) ? r_y0 : (w_step_y ? w_y_step : r_cy);
    assign w_ld      = ((r_state == SETUP) && !bus.abort) || (w_adv && !w_at_end);
    assign w_nxt_on  = ({1'b0, w_nxt_x} < HX) && ({1'b0, w_nxt_y} < VY);
    assign w_nxt_end = (w_nxt_x == r_x1) && (w_nxt_y == r_y1);

    line_addr_map #(
        .XW    (XW),
        .YW    (YW),
        .H_RES (H_RES),
        .AW    (AW)
    ) u_addr (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_en   (w_ld),
        .i_x    (w_nxt_x),
        .i_y    (w_nxt_y),
        .o_addr (bus.pix_addr)
    );

    // line FSM: command capture, setup, pixel walk, completion
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
        end else if (r_state != IDLE && bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_x0    <= bus.x0;
                        r_y0    <= bus.y0;
                        r_x1    <= bus.x1;
                        r_y1    <= bus.y1;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_dx     <= w_dx_s;
                    r_dy     <= -w_dy_s;
                    r_err    <= w_dx_s - w_dy_s;
                    r_sx_neg <= !(r_x0 < r_x1);
                    r_sy_neg <= !(r_y0 < r_y1);
                    r_cx     <= w_nxt_x;
                    r_cy     <= w_nxt_y;
                    r_valid  <= w_nxt_on;
                    r_last   <= w_nxt_end;
                    r_state  <= DRAW;
                end
                DRAW: begin
                    if (w_adv) begin
                        if (w_at_end) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cx    <= w_nxt_x;
                            r_cy    <= w_nxt_y;
                            r_err   <= w_err_nxt;
                            r_valid <= w_nxt_on;
                            r_last  <= w_nxt_end;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.pix_valid = r_valid;
    assign bus.pix_x     = r_cx;
    assign bus.pix_y     = r_cy;
    assign bus.pix_last  = r_last;
    assign bus.line_done = r_done;

endmodule

// File: tb/tb_bresen_line_gen.sv
// Bench for bresen_line_gen: directed scenarios plus random lines with
// random backpressure, checked against a plain integer Bresenham model.
module tb_bresen_line_gen;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    bresen_line_gen_if #(.XW(10), .YW(9), .AW(19)) bus ();

    bresen_line_gen #(
        .XW(10), .YW(9), .H_RES(640), .V_RES(480), .AW(19)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int ox[$], oy[$], oa[$];
    bit ol[$];
    int ex[$], ey[$], ea[$];
    bit el[$];

    // results of the last drive_line call
    int  r_lat, r_dones, r_unstable, r_done_cyc, r_last_cyc, r_ab_gap;
    bit  r_tmo;

    // Reference: visit every point of the segment, keep the visible ones.
    function automatic void model(int x0, int y0, int x1, int y1);
        int x, y, dx, dy, sx, sy, err, e2;
        ex.delete(); ey.delete(); ea.delete(); el.delete();
        x = x0; y = y0;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        forever begin
            if (x < 640 && y < 480) begin
                ex.push_back(x); ey.push_back(y); ea.push_back(y * 640 + x);
                el.push_back(x == x1 && y == y1);
            end
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    // Issue one line and record every handshaked pixel.
    task automatic drive_line(input int x0, input int y0, input int x1, input int y1,
                              input int ready_pct, input int hold_at, input int hold_len,
                              input int abort_at, input bit start_mid);
        int cyc, hs, hold_left, ab_cyc;
        bit pend, held, aborted, started;
        logic [9:0] px; logic [8:0] py; logic [18:0] pa; logic pl;
        ox.delete(); oy.delete(); oa.delete(); ol.delete();
        hs = 0; hold_left = 0; ab_cyc = 0; pend = 0; held = 0; aborted = 0; started = 0;
        r_lat = -1; r_dones = 0; r_unstable = 0; r_done_cyc = -1; r_last_cyc = -1; r_ab_gap = -1;
        @(negedge clk);
        bus.x0 = x0[9:0]; bus.y0 = y0[8:0]; bus.x1 = x1[9:0]; bus.y1 = y1[8:0];
        bus.start = 1'b1; bus.pix_ready = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 8000) begin
            if (bus.line_done === 1'b1) begin r_dones++; r_done_cyc = cyc; end
            if (bus.busy !== 1'b1) break;
            if (r_lat < 0 && bus.pix_valid === 1'b1) r_lat = cyc;
            if (pend) begin
                if (bus.pix_valid !== 1'b1 || bus.pix_x !== px || bus.pix_y !== py ||
                    bus.pix_addr !== pa || bus.pix_last !== pl) r_unstable++;
                pend = 0;
            end
            bus.abort = 1'b0; bus.start = 1'b0;
            if (hold_left > 0) begin
                bus.pix_ready = 1'b0; hold_left--;
            end else if (hold_at >= 0 && !held && hs == hold_at && bus.pix_valid === 1'b1) begin
                bus.pix_ready = 1'b0; held = 1; hold_left = hold_len - 1;
            end else begin
                bus.pix_ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (abort_at >= 0 && !aborted && hs == abort_at && bus.pix_valid === 1'b1) begin
                bus.abort = 1'b1; aborted = 1; ab_cyc = cyc;
            end
            if (start_mid && !started && hs == 1 && bus.pix_valid === 1'b1) begin
                bus.start = 1'b1; bus.x0 = 10'd0; bus.y0 = 9'd0; bus.x1 = 10'd20; bus.y1 = 9'd20;
                started = 1;
            end
            if (bus.pix_valid === 1'b1 && bus.pix_ready && !bus.abort) begin
                ox.push_back(int'(bus.pix_x)); oy.push_back(int'(bus.pix_y));
                oa.push_back(int'(bus.pix_addr)); ol.push_back(bus.pix_last);
                if (bus.pix_last === 1'b1) r_last_cyc = cyc;
                hs++;
            end else if (bus.pix_valid === 1'b1 && !bus.abort) begin
                pend = 1; px = bus.pix_x; py = bus.pix_y; pa = bus.pix_addr; pl = bus.pix_last;
            end
            @(negedge clk);
            cyc++;
        end
        r_tmo = (cyc >= 8000);
        if (aborted) r_ab_gap = cyc - ab_cyc;
        bus.abort = 1'b0; bus.start = 1'b0; bus.pix_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.line_done === 1'b1) r_dones++;
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.pix_ready = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        #3;
        n_cmp++;
        if ({bus.busy, bus.pix_valid, bus.pix_last, bus.line_done, bus.pix_x, bus.pix_y, bus.pix_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b valid=%b last=%b done=%b x=%0d y=%0d addr=%0d, want all 0",
                     bus.busy, bus.pix_valid, bus.pix_last, bus.line_done, bus.pix_x, bus.pix_y, bus.pix_addr);
        end
        @(negedge clk); n_rst = 1'b1;
    endtask

    task automatic test_reset_mid_draw;
        int bad;
        @(negedge clk);
        bus.x0 = 10'd10; bus.y0 = 9'd5; bus.x1 = 10'd13; bus.y1 = 9'd5;
        bus.start = 1'b1; bus.pix_ready = 1'b0;
        @(negedge clk); bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.pix_valid !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_drawing: valid=%b want 1", bus.pix_valid);
        end
        #2 n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.pix_valid, bus.pix_last, bus.line_done, bus.pix_x, bus.pix_y, bus.pix_addr} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: busy=%b valid=%b x=%0d y=%0d addr=%0d, want all 0",
                     bus.busy, bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_addr);
        end
        @(negedge clk); n_rst = 1'b1; bus.pix_ready = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.line_done !== 1'b0 || bus.busy !== 1'b0 || bus.pix_valid !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL rstmid_after_release: %0d active cycles, want 0", bad);
        end
        bus.pix_ready = 1'b0;
    endtask

    task automatic test_horizontal;
        int bad;
        drive_line(10, 5, 13, 5, 100, -1, 0, -1, 0);
        n_cmp++;
        if (ox.size() != 4) begin
            n_bad++; $display("FAIL horiz_count: got %0d want 4", ox.size());
        end
        bad = 0;
        for (int i = 0; i < ox.size() && i < 4; i++)
            if (ox[i] != 10 + i || oy[i] != 5 || oa[i] != 3210 + i || ol[i] != (i == 3)) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL horiz_pixels: %0d wrong pixels, want 0", bad);
        end
        n_cmp++;
        if (r_lat != 2) begin
            n_bad++; $display("FAIL horiz_latency: got %0d want 2", r_lat);
        end
        n_cmp++;
        if (r_dones != 1 || r_last_cyc < 0 || r_done_cyc != r_last_cyc + 1) begin
            n_bad++;
            $display("FAIL horiz_done: dones=%0d last_cyc=%0d done_cyc=%0d, want 1 pulse one cycle after last",
                     r_dones, r_last_cyc, r_done_cyc);
        end
    endtask

    // steep negative-direction line, optionally with a 3-cycle stall at the 3rd pixel
    task automatic test_steep(input bit stall);
        int xs[6] = '{3, 3, 2, 2, 1, 1};
        int ys[6] = '{7, 6, 5, 4, 3, 2};
        int bad;
        drive_line(3, 7, 1, 2, 100, stall ? 2 : -1, 3, -1, 0);
        n_cmp++;
        if (ox.size() != 6) begin
            n_bad++; $display("FAIL steep_count(stall=%0d): got %0d want 6", stall, ox.size());
        end
        bad = 0;
        for (int i = 0; i < ox.size() && i < 6; i++)
            if (ox[i] != xs[i] || oy[i] != ys[i] || oa[i] != ys[i] * 640 + xs[i] || ol[i] != (i == 5)) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL steep_pixels(stall=%0d): %0d wrong pixels, want 0", stall, bad);
        end
        n_cmp++;
        if (r_unstable != 0 || r_dones != 1 || r_tmo) begin
            n_bad++;
            $display("FAIL steep_stream(stall=%0d): unstable=%0d dones=%0d timeout=%0d, want 0/1/0",
                     stall, r_unstable, r_dones, r_tmo);
        end
    endtask

    task automatic test_clip;
        int bad, nlast;
        model(0, 0, 640, 480);
        drive_line(0, 0, 640, 480, 100, -1, 0, -1, 0);
        n_cmp++;
        if (ox.size() != 640 || ex.size() != 640) begin
            n_bad++; $display("FAIL clip_count: got %0d want 640", ox.size());
        end
        bad = 0; nlast = 0;
        for (int i = 0; i < ox.size(); i++) begin
            if (i >= ex.size() || ox[i] != ex[i] || oy[i] != ey[i] || oa[i] != ea[i]) bad++;
            if (ol[i]) nlast++;
        end
        n_cmp++;
        if (bad != 0 || nlast != 0) begin
            n_bad++; $display("FAIL clip_pixels: %0d wrong, %0d with last, want 0/0", bad, nlast);
        end
        n_cmp++;
        if (ox.size() == 0 || ox[ox.size()-1] != 639 || r_dones != 1) begin
            n_bad++;
            $display("FAIL clip_end: last_x=%0d dones=%0d, want 639/1",
                     (ox.size() > 0) ? ox[ox.size()-1] : -1, r_dones);
        end
    endtask

    task automatic test_start_ignored;
        int bad;
        model(30, 40, 35, 42);
        drive_line(30, 40, 35, 42, 100, -1, 0, -1, 1);
        bad = (ox.size() != ex.size()) ? 1 : 0;
        for (int i = 0; i < ox.size() && i < ex.size(); i++)
            if (ox[i] != ex[i] || oy[i] != ey[i] || oa[i] != ea[i] || ol[i] != el[i]) bad++;
        n_cmp++;
        if (bad != 0 || r_dones != 1) begin
            n_bad++;
            $display("FAIL start_in_draw: %0d bad (got %0d pixels want %0d), dones=%0d want 1",
                     bad, ox.size(), ex.size(), r_dones);
        end
    endtask

    task automatic test_abort;
        drive_line(100, 100, 110, 104, 100, -1, 0, 1, 0);
        n_cmp++;
        if (ox.size() != 1 || r_ab_gap != 1 || r_dones != 0) begin
            n_bad++;
            $display("FAIL abort: pixels=%0d gap=%0d dones=%0d, want 1/1/0", ox.size(), r_ab_gap, r_dones);
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.pix_valid !== 1'b0 || bus.pix_last !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: busy=%b valid=%b last=%b want 0", bus.busy, bus.pix_valid, bus.pix_last);
        end
    endtask

    task automatic test_zero_length;
        drive_line(7, 7, 7, 7, 100, -1, 0, -1, 0);
        n_cmp++;
        if (ox.size() != 1 || oa[0] != 4487 || ol[0] != 1'b1 || ox[0] != 7 || oy[0] != 7) begin
            n_bad++;
            $display("FAIL zero_len: pixels=%0d addr=%0d last=%0d, want 1/4487/1",
                     ox.size(), (ox.size() > 0) ? oa[0] : -1, (ox.size() > 0) ? ol[0] : 0);
        end
        n_cmp++;
        if (r_dones != 1 || r_done_cyc != r_last_cyc + 1) begin
            n_bad++; $display("FAIL zero_len_done: dones=%0d want 1", r_dones);
        end
    endtask

    task automatic test_random;
        int x0, y0, x1, y1, bad, pct;
        for (int n = 0; n < 8; n++) begin
            x0 = $urandom_range(0, 1023); y0 = $urandom_range(0, 511);
            if (n < 4) begin
                x1 = $urandom_range(0, 1023); y1 = $urandom_range(0, 511);
            end else begin
                x1 = (x0 + $urandom_range(0, 40)) % 1024; y1 = (y0 + 512 - $urandom_range(0, 40)) % 512;
            end
            pct = $urandom_range(30, 100);
            model(x0, y0, x1, y1);
            drive_line(x0, y0, x1, y1, pct, -1, 0, -1, 0);
            bad = (ox.size() != ex.size()) ? 1 : 0;
            for (int i = 0; i < ox.size() && i < ex.size(); i++)
                if (ox[i] != ex[i] || oy[i] != ey[i] || oa[i] != ea[i] || ol[i] != el[i]) bad++;
            n_cmp++;
            if (bad != 0 || r_dones != 1 || r_unstable != 0 || r_tmo) begin
                n_bad++;
                $display("FAIL random_line(%0d,%0d)->(%0d,%0d): bad=%0d got %0d pix want %0d, dones=%0d unstable=%0d tmo=%0d",
                         x0, y0, x1, y1, bad, ox.size(), ex.size(), r_dones, r_unstable, r_tmo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep(1'b0);
        test_steep(1'b1);
        test_clip();
        test_start_ignored();
        test_abort();
        test_zero_length();
        test_random();
        test_reset_mid_draw();
        test_horizontal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bresen_line_gen.md
Name: bresen_line_gen

Overview:
Parametrised successor to the fixed 640x480 Bresenham line generator. It rasterises one line segment per start command across all octants, for any screen size. Each pixel is emitted as (x, y, linear address) on a valid/ready stream, so the frame-buffer writer can apply backpressure; off-screen pixels are clipped. It sits between the primitive decoder and the frame-buffer write arbiter.

Parameters:
XW, 10, coordinate x width (bits)
YW, 9, coordinate y width (bits)
H_RES, 640, visible columns; x >= H_RES is off-screen
V_RES, 480, visible rows; y >= V_RES is off-screen
AW, 19, address width; AW must satisfy 2^AW >= H_RES*V_RES

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle command pulse; sampled only in IDLE
x0  in  XW  start x
y0  in  YW  start y
x1  in  XW  end x
y1  in  YW  end y
abort  in  1  synchronous cancel of the current line
busy  out  1  high from the cycle after an accepted start until return to IDLE
pix_valid  out  1  pixel output valid
pix_ready  in  1  downstream accepts the pixel
pix_x  out  XW  pixel x
pix_y  out  YW  pixel y
pix_addr  out  AW  pix_y*H_RES + pix_x
pix_last  out  1  current pixel is the endpoint (x1,y1)
line_done  out  1  one-cycle pulse when the line completes normally

Behaviour:
- Reset (n_rst=0, async): state=IDLE; busy, pix_valid, pix_last, line_done = 0; pix_x, pix_y, pix_addr = 0.
- States: IDLE -> SETUP -> DRAW -> DONE -> IDLE.
- IDLE:
  - start=1 latches x0..y1 and moves to SETUP.
  - start in any other state is ignored; no queueing.
- SETUP (1 cycle) computes:
  - dx = |x1-x0|, dy = -|y1-y0|
  - sx = (x0<x1) ? +1 : -1; sy = (y0<y1) ? +1 : -1
  - err = dx + dy
  - cur = (x0, y0)
  - Signed arithmetic width EW = max(XW,YW)+2; e2 = 2*err uses EW+1 bits. No overflow is permitted for any legal input.
- DRAW:
  - The cur pixel is presented; pix_x/pix_y/pix_addr/pix_last are registered and stable while pix_valid=1 and pix_ready=0.
  - On-screen pixel: pix_valid=1. The pixel advances only on pix_valid and pix_ready.
  - Clipped pixel (cur_x >= H_RES or cur_y >= V_RES): pix_valid=0 and the pixel advances unconditionally one per cycle.
  - Step rule: e2 = 2*err.
    - If e2 >= dy: err += dy, x += sx.
    - If e2 <= dx: err += dx, y += sy.
    - Both updates may occur in the same step.
  - When cur == (x1,y1) and the pixel is consumed (handshake, or clipped), go to DONE.
- Latency: start at cycle N -> first pix_valid at N+2 (if on-screen). With pix_ready held high, one pixel per cycle. Iteration count = max(dx,|dy|)+1.
- pix_last is asserted only with the endpoint. If the endpoint is clipped, no pixel carries pix_last.
- DONE (1 cycle): line_done=1, busy=1. The next cycle is IDLE with busy=0.
- Zero-length line (x0==x1, y0==y1): exactly one pixel with pix_last=1, then line_done.
- abort=1 in SETUP/DRAW/DONE: next cycle is IDLE. pix_valid, pix_last, line_done and busy all drop; no line_done is produced. abort has priority over handshake. abort in IDLE has no effect.
- Simultaneous abort and start in IDLE: start is accepted.
- pix_addr is computed from the next-cycle coordinates and registered, so it has no combinational multiply on the output path. Multiply by constant H_RES.

Decomposition:
- Package gfx_pkg holds:
  - default H_RES/V_RES/XW/YW/AW constants
  - the coord_x_t/coord_y_t/addr_t typedefs
  - the line_state_t enum {IDLE, SETUP, DRAW, DONE}
- One sub-module, line_addr_map: registered (x,y) -> y*H_RES + x, parametrised on H_RES/AW. It is reused by the future circle and triangle generators.

Test Plan:
- Reset: assert n_rst=0 mid-DRAW -> all outputs 0 immediately and state IDLE; no line_done after release.
- Horizontal (10,5)->(13,5), ready=1: pixels (10,5),(11,5),(12,5),(13,5), addrs 3210..3213, first valid 2 cycles after start; pix_last on the 4th; line_done 1 cycle later.
- Steep negative (3,7)->(1,2): exact sequence (3,7),(3,6),(2,5),(2,4),(1,3),(1,2); pix_last on (1,2); 6 handshakes.
- Backpressure on the (3,7)->(1,2) line: pix_ready=0 for 3 cycles at the 3rd pixel -> (2,5)/addr 3202 held stable; no skipped or duplicated pixel; total 6 handshakes.
- Clipping (0,0)->(640,480): 641 iterations, 640 on-screen pixels handshaked, last emitted x=639; the endpoint is clipped so pix_last is never asserted; line_done pulses once.
- Control: start during DRAW is ignored; abort at the 2nd pixel -> IDLE next cycle with no line_done; zero-length (7,7)->(7,7) -> one pixel, addr 4487, pix_last=1, then line_done.
